// File: rtl/alu_div_seq_if.sv
// alu_div_seq_if: command/result handshake bundle for the sequential divider.
//   master : command source / result sink (drives in_valid, operands, out_ready)
//   slave  : the divider (drives in_ready, out_valid, quotient, remainder, div_zero)
interface alu_div_seq_if;
  localparam int unsigned W = 32;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/alu_div_seq.sv
// alu_div_seq: 32-bit unsigned restoring divider, one quotient bit per cycle,
// using an external 32-bit ALU configured as a subtractor.
//   clk, rst              : clock, asynchronous active-high reset
//   bus (slave)           : in_valid/in_ready command handshake with dividend/divisor,
//                           out_valid/out_ready result handshake with quotient/remainder/div_zero
//   alu_src1, alu_src2    : operands to the external ALU (shifted partial remainder, divisor)
//   alu_A_invert .. alu_less : constant ALU controls selecting src1 - src2
//   alu_result, alu_cout  : ALU difference and carry (1 = no borrow)
module alu_div_seq (
  input  logic                clk,
  input  logic                rst,
  alu_div_seq_if.slave        bus,
  output logic [31:0]         alu_src1,
  output logic [31:0]         alu_src2,
  output logic                alu_A_invert,
  output logic                alu_B_invert,
  output logic                alu_cin,
  output logic [1:0]          alu_operation,
  output logic                alu_less,
  input  logic [31:0]         alu_result,
  input  logic                alu_cout
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dz_q, dz_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    src1_c;
  logic            qbit_c;

  // Shift next dividend bit into the partial remainder; a set R[31] means the
  // 33-bit shifted value exceeds any 32-bit divisor, so the subtract always succeeds.
  assign src1_c = {r_q[W-2:0], q_q[W-1]};
  assign qbit_c = alu_cout | r_q[W-1];

  // ALU wired permanently as src1 + ~src2 + 1
  assign alu_src1      = src1_c;
  assign alu_src2      = d_q;
  assign alu_A_invert  = 1'b0;
  assign alu_B_invert  = 1'b1;
  assign alu_cin       = 1'b1;
  assign alu_operation = 2'b10;
  assign alu_less      = 1'b0;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          d_d   = bus.divisor;
          q_d   = bus.dividend;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = qbit_c ? alu_result : src1_c;
        q_d   = {q_q[W-2:0], qbit_c};
        cnt_d = CW'(cnt_q + CW'(1));
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_d;
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: scoreboard bench for alu_div_seq with a behavioural ALU and
// plain-arithmetic divide reference.
module tb_alu_div_seq;

  logic        clk;
  logic        rst;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        alu_A_invert, alu_B_invert, alu_cin, alu_less, alu_cout;
  logic [1:0]  alu_operation;

  alu_div_seq_if bus ();

  alu_div_seq dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alu_src1      (alu_src1),
    .alu_src2      (alu_src2),
    .alu_A_invert  (alu_A_invert),
    .alu_B_invert  (alu_B_invert),
    .alu_cin       (alu_cin),
    .alu_operation (alu_operation),
    .alu_less      (alu_less),
    .alu_result    (alu_result),
    .alu_cout      (alu_cout)
  );

  // External ALU: operand inversion, carry-in, sum path; other ops return AND
  logic [31:0] a_op, b_op;
  logic [32:0] sum33;
  always_comb begin
    a_op  = alu_A_invert ? ~alu_src1 : alu_src1;
    b_op  = alu_B_invert ? ~alu_src2 : alu_src2;
    sum33 = {1'b0, a_op} + {1'b0, b_op} + {32'b0, alu_cin};
    if (alu_operation == 2'b10) begin
      alu_result = sum33[31:0];
      alu_cout   = sum33[32];
    end else begin
      alu_result = a_op & b_op;
      alu_cout   = 1'b0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   ordy_mode = 2;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Consumer ready: random, held low, or held high
  always @(posedge clk) begin
    #1;
    case (ordy_mode)
      0:       bus.out_ready = 1'($urandom_range(0, 1));
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on the first DONE cycle, then checks stability
  logic        mon_seen = 1'b0;
  logic        handoff_prev = 1'b0;
  exp_t        cur;
  logic [31:0] hq, hr;
  logic        hdz;
  always @(negedge clk) begin
    if (rst) begin
      mon_seen     = 1'b0;
      handoff_prev = 1'b0;
    end else begin
      if (handoff_prev) begin
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
      handoff_prev = 1'b0;
      if (bus.out_valid) begin
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        if (!mon_seen) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result quotient=%h remainder=%h", bus.quotient, bus.remainder);
          end else begin
            cur = expq.pop_front();
            chk("quotient", bus.quotient, cur.q);
            chk("remainder", bus.remainder, cur.r);
            chk("div_zero", 32'(bus.div_zero), 32'(cur.dz));
            chk("latency", 32'(cyc - cur.acc), cur.dz ? 32'd0 : 32'd32);
          end
          mon_seen = 1'b1;
          hq  = bus.quotient;
          hr  = bus.remainder;
          hdz = bus.div_zero;
        end else begin
          chk("hold_quotient", bus.quotient, hq);
          chk("hold_remainder", bus.remainder, hr);
          chk("hold_div_zero", 32'(bus.div_zero), 32'(hdz));
        end
        if (bus.out_ready) begin
          mon_seen     = 1'b0;
          handoff_prev = 1'b1;
        end
      end
    end
  end

  // Issue one command; optionally wiggle the command inputs while busy
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit noise);
    exp_t e;
    int   n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      return;
    end
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dz  = (b == 0);
    e.acc = cyc + 1;
    expq.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    if (noise && b != 0) begin
      repeat (20) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (expq.size() == 0 && !mon_seen && !bus.out_valid) break;
    end
    if (expq.size() != 0 || mon_seen) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0_pending", expq.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_quotient"}, bus.quotient, 32'd0);
    chk({tag, "_remainder"}, bus.remainder, 32'd0);
    chk({tag, "_div_zero"}, 32'(bus.div_zero), 32'd0);
    chk({tag, "_alu_src1"}, alu_src1, 32'd0);
    chk({tag, "_alu_src2"}, alu_src2, 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    expq.delete();
    #1 check_reset_values(tag);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Stimulus
  initial begin
    logic [31:0] a, b;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    #1;
    check_reset_values("por");
    chk("alu_A_invert", 32'(alu_A_invert), 32'd0);
    chk("alu_B_invert", 32'(alu_B_invert), 32'd1);
    chk("alu_cin", 32'(alu_cin), 32'd1);
    chk("alu_operation", 32'(alu_operation), 32'd2);
    chk("alu_less", 32'(alu_less), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Directed cases
    ordy_mode = 2;
    send(32'd100, 32'd7, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 1'b0);
    send(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    send(32'd5, 32'd0, 1'b0);
    send(32'd0, 32'd9, 1'b0);
    send(32'd7, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Result held back for 10 cycles, then released and a second command follows
    ordy_mode = 1;
    send(32'd100, 32'd7, 1'b1);
    for (int n = 0; n < 100 && !bus.out_valid; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    ordy_mode = 2;
    send(32'd3, 32'd9, 1'b0);
    drain();

    // Reset in the middle of a computation
    send(32'd1000, 32'd3, 1'b0);
    repeat (15) @(negedge clk);
    pulse_reset("rst_calc");
    send(32'd12, 32'd4, 1'b0);
    drain();

    // Reset while a zero-divisor result is parked in DONE
    ordy_mode = 1;
    send(32'd5, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    pulse_reset("rst_done");
    ordy_mode = 2;
    send(32'd12, 32'd4, 1'b0);
    drain();

    // Randomized traffic with random consumer back-pressure
    ordy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = $urandom;
        3:       b = a >> $urandom_range(0, 31);
        default: b = 32'h8000_0000 | $urandom;
      endcase
      send(a, b, 1'($urandom_range(0, 1)));
    end
    ordy_mode = 2;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_div_seq.md
ALU_DIV_SEQ -- requirements
Module: alu_div_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  command request.
REQ-004 in_ready  output  1  block can accept a command; high only in IDLE.
REQ-005 dividend  input  32  unsigned dividend, sampled on the accept edge.
REQ-006 divisor  input  32  unsigned divisor, sampled on the accept edge.
REQ-007 out_valid  output  1  result available; high only in DONE.
REQ-008 out_ready  input  1  consumer takes the result.
REQ-009 quotient  output  32  quotient register.
REQ-010 remainder  output  32  remainder register.
REQ-011 div_zero  output  1  last result came from a zero divisor.
REQ-012 alu_src1  output  32  shifted partial remainder driven to the external 32-bit ALU.
REQ-013 alu_src2  output  32  latched divisor driven to the ALU.
REQ-014 alu_A_invert, alu_B_invert, alu_cin  output  1 each  ALU controls; constant 0, 1, 1 (subtract).
REQ-015 alu_operation  output  2  constant 2'b10 (sum path).
REQ-016 alu_less  output  1  constant 0.
REQ-017 alu_result  input  32  ALU sum, combinational from alu_src1/alu_src2 in the same cycle.
REQ-018 alu_cout  input  1  ALU carry out; 1 = no borrow (src1 >= src2).

Function
REQ-019 The block SHALL use the states IDLE, CALC and DONE.
REQ-020 Accept is in_valid & in_ready in IDLE. On accept: D <= divisor, Q <= dividend, R <= 0, count <= 0, next state CALC. If divisor == 0, next state is DONE instead, with quotient = 32'hFFFFFFFF, remainder = dividend and div_zero = 1.
REQ-021 Each CALC cycle: alu_src1 = {R[30:0], Q[31]}; qbit = alu_cout | R[31].
REQ-022 Update on each CALC cycle: if qbit, R <= alu_result, else R <= alu_src1; Q <= {Q[30:0], qbit}; count <= count + 1.
REQ-023 The R[31] term covers a 33-bit shifted value, which is always >= D; alu_result modulo 2^32 is then the correct remainder.
REQ-024 After the CALC cycle with count == 31, the state SHALL go to DONE. quotient = Q, remainder = R, div_zero = 0.
REQ-025 Latency: exactly 32 CALC cycles. out_valid rises on the 33rd rising edge after the accept edge; for a zero divisor it rises on the 1st edge.
REQ-026 In DONE, out_valid stays high and quotient, remainder and div_zero stay stable until out_ready is sampled high. On that edge the state returns to IDLE.
REQ-027 in_ready is 0 in CALC and DONE. in_valid is ignored there, with no queuing; dividend/divisor changes during CALC have no effect.
REQ-028 out_ready is ignored outside DONE.
REQ-029 DONE to IDLE takes one edge. A new accept is possible on the next edge, so there is no back-to-back accept in the same cycle as the result handoff.
REQ-030 quotient, remainder and div_zero hold their last values in IDLE and CALC until overwritten on entry to DONE.
REQ-031 alu_src1/alu_src2 are don't-care outside CALC but SHALL be driven, never X after reset.

Reset
REQ-032 rst high SHALL immediately force: state IDLE; in_ready 1; out_valid 0; quotient, remainder, R, Q, D 0; count 0; div_zero 0. This holds mid-CALC or mid-DONE with no clock required.
REQ-033 After rst deasserts, the first accept is possible on the first rising edge.

Verification
REQ-034 100 / 7 -> out_valid 33 edges after accept; quotient 14, remainder 2, div_zero 0.
REQ-035 32'hFFFFFFFF / 1 -> quotient 32'hFFFFFFFF, remainder 0. This exercises the R[31] path (also check 32'hFFFFFFFF / 32'h80000001 -> quotient 1, remainder 32'h7FFFFFFE).
REQ-036 5 / 0 -> out_valid on the 1st edge; quotient 32'hFFFFFFFF, remainder 5, div_zero 1.
REQ-037 out_ready held low 10 cycles in DONE -> outputs stable, in_ready 0; out_ready high -> IDLE next edge, then a second command (3 / 9 -> quotient 0, remainder 3) is accepted.
REQ-038 rst pulse asserted at CALC count 15, then 12 / 4 issued -> all outputs zero immediately; the new result is quotient 3, remainder 0 with no residue from the aborted run.
REQ-039 in_valid toggled during CALC with different operands -> ignored; the result matches the operands captured on the original accept.
